// File: rtl/wb_cacheop_sequencer.sv
// Sequences writeback-stage TLB and CACHE ops: issues TLB/cache maintenance requests, then flushes to pc+4.
// Latency: TLB ops refetch 2 cycles after accept; cache ops refetch 1 cycle after ack+done (or WAIT_LIMIT timeout).
// Backpressure: ws_stall holds WB from the accept cycle through the flush cycle; cache reqs held until acked.
module wb_cacheop_sequencer #(
  parameter int ADDR_W     = 32,
  parameter int WAIT_LIMIT = 255,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  input  logic [1:0]        op_kind,
  input  logic              cache_sel,
  input  logic [2:0]        cache_code,
  input  logic [ADDR_W-1:0] op_vaddr,
  input  logic [ADDR_W-1:0] op_paddr,
  input  logic [ADDR_W-1:0] op_pc,
  input  logic              ex_en,
  output logic              ws_stall,
  output logic [2:0]        tlb_req,
  output logic              ic_req,
  output logic              dc_req,
  output logic [2:0]        c_code,
  output logic [ADDR_W-1:0] c_vaddr,
  output logic [ADDR_W-1:0] c_paddr,
  input  logic              ic_ack,
  input  logic              dc_ack,
  input  logic              c_done,
  output logic              refetch,
  output logic [ADDR_W-1:0] refetch_pc,
  output logic              timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TLB,
    S_C_REQ,
    S_C_WAIT,
    S_FLUSH
  } state_t;

  // Timeout fires on the cycle the counter reads WAIT_LIMIT-1, i.e. after WAIT_LIMIT wait cycles.
  localparam int unsigned LIM_M1 = (WAIT_LIMIT == 0) ? 0 : WAIT_LIMIT - 1;
  localparam logic [CNT_W-1:0] LIMIT_M1 = LIM_M1[CNT_W-1:0];
  localparam bit TMO_EN = (WAIT_LIMIT != 0);

  state_t            state;
  logic              sel_q;
  logic [ADDR_W-1:0] pc_q;
  logic [CNT_W-1:0]  cnt;
  logic              accept;
  logic              ack_sel;

  assign accept   = (state == S_IDLE) & op_valid & ~ex_en;
  assign ws_stall = (state != S_IDLE) | accept;
  // Only the ack of the cache actually addressed counts; the other one is noise.
  assign ack_sel  = sel_q ? dc_ack : ic_ack;

  // Single FSM with all outputs registered; tlb_req/refetch/timeout default low so they pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      sel_q      <= 1'b0;
      pc_q       <= '0;
      cnt        <= '0;
      tlb_req    <= '0;
      ic_req     <= 1'b0;
      dc_req     <= 1'b0;
      c_code     <= '0;
      c_vaddr    <= '0;
      c_paddr    <= '0;
      refetch    <= 1'b0;
      refetch_pc <= '0;
      timeout    <= 1'b0;
    end else begin
      tlb_req <= '0;
      refetch <= 1'b0;
      timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            sel_q   <= cache_sel;
            pc_q    <= op_pc;
            c_code  <= cache_code;
            c_vaddr <= op_vaddr;
            c_paddr <= op_paddr;
            if (op_kind == 2'd3) begin
              ic_req <= ~cache_sel;
              dc_req <= cache_sel;
              state  <= S_C_REQ;
            end else begin
              tlb_req <= 3'(3'b001 << op_kind);
              state   <= S_TLB;
            end
          end
        end
        S_TLB: begin
          // TLB completes within its strobe cycle, so flush immediately.
          refetch    <= 1'b1;
          refetch_pc <= pc_q + ADDR_W'(4);
          state      <= S_FLUSH;
        end
        S_C_REQ: begin
          if (ack_sel) begin
            ic_req <= 1'b0;
            dc_req <= 1'b0;
            cnt    <= '0;
            if (c_done) begin
              refetch    <= 1'b1;
              refetch_pc <= pc_q + ADDR_W'(4);
              state      <= S_FLUSH;
            end else begin
              state <= S_C_WAIT;
            end
          end
        end
        S_C_WAIT: begin
          if (cnt != '1) cnt <= cnt + 1'b1;
          // A late c_done on the limit cycle still counts as a normal completion.
          if (c_done) begin
            refetch    <= 1'b1;
            refetch_pc <= pc_q + ADDR_W'(4);
            state      <= S_FLUSH;
          end else if (TMO_EN && cnt == LIMIT_M1) begin
            refetch    <= 1'b1;
            refetch_pc <= pc_q + ADDR_W'(4);
            timeout    <= 1'b1;
            state      <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
